// File: rtl/m_axi_lite_tg_pkg.sv
// m_axi_lite_tg_pkg: shared encodings and helpers for the AXI4-Lite traffic generator
package m_axi_lite_tg_pkg;
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    for (int x = v - 1; x > 0; x >>= 1) r++;
    return r;
  endfunction
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  localparam logic [1:0] MODE_WRC = 2'b00;
  localparam logic [1:0] MODE_WO  = 2'b01;
  localparam logic [1:0] MODE_RC  = 2'b10;
  localparam logic [1:0] MODE_RO  = 2'b11;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  function automatic logic resp_err(input logic [1:0] r);
    return r == SLVERR || r == DECERR;
  endfunction
endpackage

// File: rtl/tg_pattern.sv
// tg_pattern: beat address and data word derived from latched base, seed and beat index
module tg_pattern import m_axi_lite_tg_pkg::*; #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int CNT_BIT = 9
) (
  input  logic [AWIDTH-1:0]  base,
  input  logic [DWIDTH-1:0]  seed,
  input  logic [CNT_BIT-1:0] idx,
  output logic [AWIDTH-1:0]  addr,
  output logic [DWIDTH-1:0]  data
);
  localparam int SH = clogb2(DWIDTH / 8);
  assign addr = base + (AWIDTH'(idx) << SH);
  assign data = seed + DWIDTH'(idx);
endmodule

// File: rtl/m_axi_lite_tg.sv
// m_axi_lite_tg: AXI4-Lite master issuing seeded write/readback/compare runs, one beat in flight
module m_axi_lite_tg import m_axi_lite_tg_pkg::*; #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int TXN_MAX = 256,
  parameter int CNT_BIT = clogb2(TXN_MAX) + 1
) (
  input  logic                clk,
  input  logic                xrst,
  input  logic                req,
  input  logic [CNT_BIT-1:0]  txn_num,
  input  logic [AWIDTH-1:0]   base_addr,
  input  logic [DWIDTH-1:0]   seed,
  input  logic [1:0]          mode,
  output logic                ack,
  output logic                busy,
  output logic [3:0]          err,
  output logic [CNT_BIT-1:0]  err_cnt,
  output logic [DWIDTH-1:0]   probe,
  output logic                awvalid,
  output logic [AWIDTH-1:0]   awaddr,
  output logic [2:0]          awprot,
  input  logic                awready,
  output logic                wvalid,
  output logic [DWIDTH-1:0]   wdata,
  output logic [DWIDTH/8-1:0] wstrb,
  input  logic                wready,
  input  logic                bvalid,
  input  logic [1:0]          bresp,
  output logic                bready,
  output logic                arvalid,
  output logic [AWIDTH-1:0]   araddr,
  output logic [2:0]          arprot,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [DWIDTH-1:0]   rdata,
  input  logic [1:0]          rresp,
  output logic                rready
);
  state_t state, state_nxt;
  logic r_req, pend, mode_lo, req_pulse, b_hs, r_hs, last, e_b, e_r, e_mis, e_any;
  logic [CNT_BIT-1:0] txn_r, idx, idx_nxt;
  logic [AWIDTH-1:0] base_r, addr;
  logic [DWIDTH-1:0] seed_r, exp_data;
  tg_pattern #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .CNT_BIT(CNT_BIT)) u_pattern (
    .base(base_r), .seed(seed_r), .idx(idx), .addr(addr), .data(exp_data)
  );
  assign req_pulse = req & ~r_req;
  assign bready = state == WRITE;
  assign rready = state == READ;
  assign busy = state != IDLE;
  assign b_hs = bvalid & bready;
  assign r_hs = rvalid & rready;
  assign idx_nxt = idx + CNT_BIT'(1);
  assign last = idx_nxt == txn_r;
  assign e_b = b_hs & resp_err(bresp);
  assign e_r = r_hs & resp_err(rresp);
  assign e_mis = r_hs & ~mode_lo & (rdata != exp_data);
  assign e_any = e_b | e_r | e_mis;
  assign awaddr = addr;
  assign araddr = addr;
  assign wdata = exp_data;
  assign wstrb = '1;
  assign awprot = '0;
  assign arprot = '0;
  assign probe = {{(DWIDTH-2){1'b0}}, state};
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_pulse) state_nxt = txn_num == '0 ? DONE : mode[1] ? READ : WRITE;
      WRITE:   if (b_hs && last) state_nxt = mode_lo ? DONE : READ;
      READ:    if (r_hs && last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end
  // pend marks a beat whose response is still owed; the next beat issues the cycle after it clears
  always_ff @(posedge clk or negedge xrst)
    if (!xrst) begin
      r_req   <= 1'b0;
      pend    <= 1'b0;
      mode_lo <= 1'b0;
      txn_r   <= '0;
      idx     <= '0;
      base_r  <= '0;
      seed_r  <= '0;
      ack     <= 1'b0;
      err     <= '0;
      err_cnt <= '0;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      arvalid <= 1'b0;
    end else begin
      r_req <= req;
      if (awvalid && awready) awvalid <= 1'b0;
      if (wvalid && wready) wvalid <= 1'b0;
      if (arvalid && arready) arvalid <= 1'b0;
      if (state == IDLE && req_pulse) begin
        txn_r   <= txn_num;
        base_r  <= base_addr;
        seed_r  <= seed;
        mode_lo <= mode[0];
        ack     <= 1'b0;
        err     <= '0;
        err_cnt <= '0;
        idx     <= '0;
        pend    <= txn_num != '0;
        awvalid <= txn_num != '0 && !mode[1];
        wvalid  <= txn_num != '0 && !mode[1];
        arvalid <= txn_num != '0 && mode[1];
      end
      if (state == WRITE && !pend) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        pend    <= 1'b1;
      end
      if (state == READ && !pend) begin
        arvalid <= 1'b1;
        pend    <= 1'b1;
      end
      if (b_hs || r_hs) begin
        pend <= 1'b0;
        idx  <= last ? '0 : idx_nxt;
      end
      if (e_any) begin
        err <= err | {e_mis, e_r, e_b, 1'b1};
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_BIT'(1);
      end
      if (state == DONE) ack <= 1'b1;
    end
endmodule
